// File: rtl/pc_select.sv
// Fetch PC selection for a Y86-64 pipeline: prediction, return wait, halt and redirect.
// Optional macro PC_SELECT_BTFN_EN selects backward-taken/forward-not-taken JXX prediction.
module pc_select #(
  parameter logic [63:0] RESET_VECTOR = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  f_icode,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic        stall,
  input  logic        mispredict,
  input  logic [63:0] resolve_target,
  input  logic        ret_valid,
  input  logic [63:0] ret_addr,
  output logic [63:0] pc,
  output logic        pc_valid,
  output logic        halted
);

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned ICODE_W = 4;

  localparam logic [ICODE_W-1:0] ICODE_HALT = ICODE_W'(0);
  localparam logic [ICODE_W-1:0] ICODE_JXX  = ICODE_W'(7);
  localparam logic [ICODE_W-1:0] ICODE_CALL = ICODE_W'(8);
  localparam logic [ICODE_W-1:0] ICODE_RET  = ICODE_W'(9);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    RET_WAIT = 2'd1,
    HALTED   = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   pc_nxt;
  logic [ADDR_W-1:0]   jxx_target;

  // Predicted successor of a conditional jump.
`ifdef PC_SELECT_BTFN_EN
  assign jxx_target = (f_valC < pc) ? f_valC : f_valP;
`else
  assign jxx_target = f_valC;
`endif

  assign pc_valid = (state == RUN);
  assign halted   = (state == HALTED);

  // State and PC register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      pc    <= RESET_VECTOR;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Next-state and next-PC selection; a mispredict redirect beats everything but reset.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if (mispredict) begin
      state_nxt = RUN;
      pc_nxt    = resolve_target;
    end else if (!stall) begin
      unique case (state)
        RUN: begin
          unique case (f_icode)
            ICODE_JXX:  pc_nxt    = jxx_target;
            ICODE_CALL: pc_nxt    = f_valC;
            ICODE_RET:  state_nxt = RET_WAIT;
            ICODE_HALT: state_nxt = HALTED;
            default:    pc_nxt    = f_valP;
          endcase
        end
        RET_WAIT: begin
          if (ret_valid) begin
            state_nxt = RUN;
            pc_nxt    = ret_addr;
          end
        end
        HALTED: begin
          state_nxt = HALTED;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_select.sv
// Directed self-checking bench for pc_select with RESET_VECTOR = 0x100.
module tb_pc_select;

  localparam logic [63:0] RV = 64'h100;
  localparam logic [3:0] HALT = 4'h0, NOP = 4'h1, JXX = 4'h7, CALL = 4'h8, RET = 4'h9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  f_icode;
  logic [63:0] f_valC, f_valP, resolve_target, ret_addr;
  logic        stall, mispredict, ret_valid;
  logic [63:0] pc;
  logic        pc_valid, halted;

  int checks = 0;
  int errors = 0;

  pc_select #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .rst_n(rst_n), .f_icode(f_icode), .f_valC(f_valC), .f_valP(f_valP),
    .stall(stall), .mispredict(mispredict), .resolve_target(resolve_target),
    .ret_valid(ret_valid), .ret_addr(ret_addr), .pc(pc), .pc_valid(pc_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    f_icode = NOP; f_valC = 64'h0; f_valP = 64'h0; stall = 1'b0;
    mispredict = 1'b0; resolve_target = 64'h0; ret_valid = 1'b0; ret_addr = 64'h0;
  endtask

  task automatic redirect(input logic [63:0] tgt);
    idle_inputs();
    mispredict = 1'b1; resolve_target = tgt;
    step();
    mispredict = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    f_icode = HALT; mispredict = 1'b1; resolve_target = 64'h555; ret_valid = 1'b1;
    step();
    checks++;
    if ({pc, pc_valid, halted} !== {RV, 1'b1, 1'b0}) begin
      $display("FAIL reset_state: pc=%h valid=%b halted=%b, expected pc=%h valid=1 halted=0", pc, pc_valid, halted, RV);
      errors++;
    end
    rst_n = 1'b1;
    idle_inputs();
    f_icode = NOP; f_valP = 64'h101;
    checks++;
    if ({pc, pc_valid} !== {RV, 1'b1}) begin
      $display("FAIL reset_hold_before_edge: pc=%h valid=%b, expected pc=%h valid=1", pc, pc_valid, RV);
      errors++;
    end
    step();
    checks++;
    if ({pc, pc_valid} !== {64'h101, 1'b1}) begin
      $display("FAIL nop_sequential: pc=%h valid=%b, expected pc=101 valid=1", pc, pc_valid);
      errors++;
    end
  endtask

  task automatic test_jxx();
    logic [63:0] exp_fwd;
`ifdef PC_SELECT_BTFN_EN
    exp_fwd = 64'h209;
`else
    exp_fwd = 64'h300;
`endif
    redirect(64'h200);
    checks++;
    if (pc !== 64'h200) begin
      $display("FAIL redirect_200: pc=%h, expected 200", pc);
      errors++;
    end
    f_icode = JXX; f_valC = 64'h180; f_valP = 64'h209;
    step();
    checks++;
    if (pc !== 64'h180) begin
      $display("FAIL jxx_backward: pc=%h, expected 180", pc);
      errors++;
    end
    redirect(64'h200);
    f_icode = JXX; f_valC = 64'h300; f_valP = 64'h209;
    step();
    checks++;
    if (pc !== exp_fwd) begin
      $display("FAIL jxx_forward: pc=%h, expected %h", pc, exp_fwd);
      errors++;
    end
    idle_inputs();
    f_icode = NOP; f_valP = 64'h3f0; ret_valid = 1'b1; ret_addr = 64'hdead;
    step();
    checks++;
    if ({pc, pc_valid} !== {64'h3f0, 1'b1}) begin
      $display("FAIL ret_valid_ignored_in_run: pc=%h valid=%b, expected pc=3f0 valid=1", pc, pc_valid);
      errors++;
    end
  endtask

  task automatic test_ret();
    redirect(64'h40);
    f_icode = RET; f_valP = 64'h41;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({pc, pc_valid, halted} !== {64'h40, 1'b0, 1'b0}) begin
        $display("FAIL ret_wait_%0d: pc=%h valid=%b halted=%b, expected pc=40 valid=0 halted=0", i, pc, pc_valid, halted);
        errors++;
      end
      f_icode = CALL; f_valC = 64'h9999;
      step();
    end
    stall = 1'b1; ret_valid = 1'b1; ret_addr = 64'h77;
    step();
    checks++;
    if ({pc, pc_valid} !== {64'h40, 1'b0}) begin
      $display("FAIL ret_lost_under_stall: pc=%h valid=%b, expected pc=40 valid=0", pc, pc_valid);
      errors++;
    end
    stall = 1'b0; ret_valid = 1'b1; ret_addr = 64'h88;
    step();
    ret_valid = 1'b0;
    checks++;
    if ({pc, pc_valid} !== {64'h88, 1'b1}) begin
      $display("FAIL ret_return: pc=%h valid=%b, expected pc=88 valid=1", pc, pc_valid);
      errors++;
    end
    f_icode = RET;
    step();
    idle_inputs();
    mispredict = 1'b1; resolve_target = 64'h600;
    step();
    mispredict = 1'b0;
    checks++;
    if ({pc, pc_valid} !== {64'h600, 1'b1}) begin
      $display("FAIL mispredict_squash_ret: pc=%h valid=%b, expected pc=600 valid=1", pc, pc_valid);
      errors++;
    end
  endtask

  task automatic test_halt();
    redirect(64'h2a0);
    f_icode = HALT; f_valP = 64'h2a1;
    step();
    checks++;
    if ({pc, pc_valid, halted} !== {64'h2a0, 1'b0, 1'b1}) begin
      $display("FAIL halt_enter: pc=%h valid=%b halted=%b, expected pc=2a0 valid=0 halted=1", pc, pc_valid, halted);
      errors++;
    end
    f_icode = CALL; f_valC = 64'h1234; ret_valid = 1'b1; ret_addr = 64'h4321;
    for (int i = 0; i < 20; i++) step();
    checks++;
    if ({pc, halted} !== {64'h2a0, 1'b1}) begin
      $display("FAIL halt_frozen: pc=%h halted=%b, expected pc=2a0 halted=1", pc, halted);
      errors++;
    end
    idle_inputs();
    mispredict = 1'b1; resolve_target = 64'h500;
    step();
    mispredict = 1'b0;
    checks++;
    if ({pc, pc_valid, halted} !== {64'h500, 1'b1, 1'b0}) begin
      $display("FAIL halt_exit_mispredict: pc=%h valid=%b halted=%b, expected pc=500 valid=1 halted=0", pc, pc_valid, halted);
      errors++;
    end
  endtask

  task automatic test_stall();
    idle_inputs();
    stall = 1'b1; mispredict = 1'b1; resolve_target = 64'h77;
    step();
    checks++;
    if (pc !== 64'h77) begin
      $display("FAIL stall_with_mispredict: pc=%h, expected 77", pc);
      errors++;
    end
    mispredict = 1'b0; f_icode = CALL; f_valC = 64'h1234;
    step();
    checks++;
    if ({pc, pc_valid} !== {64'h77, 1'b1}) begin
      $display("FAIL stall_holds_call: pc=%h valid=%b, expected pc=77 valid=1", pc, pc_valid);
      errors++;
    end
    stall = 1'b0;
    step();
    checks++;
    if (pc !== 64'h1234) begin
      $display("FAIL call_target: pc=%h, expected 1234", pc);
      errors++;
    end
    f_icode = NOP; f_valP = 64'h0;
    redirect(64'hffff_ffff_ffff_fff0);
    f_icode = NOP; f_valP = 64'h0000_0000_0000_0002;
    step();
    checks++;
    if (pc !== 64'h2) begin
      $display("FAIL wrap_sequential: pc=%h, expected 2", pc);
      errors++;
    end
  endtask

  task automatic test_reset_in_ret_wait();
    redirect(64'h50);
    f_icode = RET;
    step();
    idle_inputs();
    rst_n = 1'b0; ret_valid = 1'b1; ret_addr = 64'h99;
    step();
    checks++;
    if ({pc, pc_valid, halted} !== {RV, 1'b1, 1'b0}) begin
      $display("FAIL reset_in_ret_wait: pc=%h valid=%b halted=%b, expected pc=%h valid=1 halted=0", pc, pc_valid, halted, RV);
      errors++;
    end
    rst_n = 1'b1; ret_valid = 1'b0; f_icode = NOP; f_valP = 64'h104;
    step();
    checks++;
    if ({pc, pc_valid} !== {64'h104, 1'b1}) begin
      $display("FAIL run_after_reset: pc=%h valid=%b, expected pc=104 valid=1", pc, pc_valid);
      errors++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #2;
    test_reset();
    test_jxx();
    test_ret();
    test_halt();
    test_stall();
    test_reset_in_ret_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
